// File: rtl/serial_frame_feeder.sv
// Parallel-to-serial frame feeder: accepts words on a valid/ready handshake and
// emits them one bit per programmable bit period, with a per-bit clock-enable strobe.
module serial_frame_feeder #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIV_W = 4,
   parameter int unsigned FCW   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DIV_W-1:0] div,
   input  logic             msb_first,
   output logic             so,
   output logic             so_en,
   output logic             busy,
   output logic             done,
   output logic [FCW-1:0]   frame_cnt
);

   localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state;
   logic [WIDTH-1:0] word;
   logic [BW-1:0]    bit_cnt;
   logic [DIV_W-1:0] tick;
   logic [DIV_W-1:0] div_l;
   logic [FCW-1:0]   cnt;
   logic             strobe;
   logic             last;
   logic             accept;
   logic [WIDTH-1:0] load_word;

   function automatic logic [WIDTH-1:0] reverse(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < WIDTH; i++)
         r[i] = v[WIDTH-1-i];
      return r;
   endfunction

   // Words are stored in send order so the outgoing bit is always word[WIDTH-1];
   // bit order is resolved once at load, which is how msb_first gets latched.
   assign load_word = msb_first ? in_data : reverse(in_data);

   assign strobe   = (state == SHIFT) && (tick == '0);
   assign last     = strobe && (bit_cnt == LAST_BIT);
   assign in_ready = (state == IDLE) || last;
   assign accept   = in_valid && in_ready;

   assign so_en     = strobe;
   assign done      = last;
   assign busy      = (state == SHIFT);
   assign so        = word[WIDTH-1];
   assign frame_cnt = cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         word    <= '0;
         bit_cnt <= '0;
         tick    <= '0;
         div_l   <= '0;
         cnt     <= '0;
      end else begin
         if (last)
            cnt <= cnt + FCW'(1);
         if (accept) begin
            state   <= SHIFT;
            word    <= load_word;
            div_l   <= div;
            tick    <= div;
            bit_cnt <= '0;
         end else if (state == SHIFT) begin
            if (tick != '0) begin
               tick <= tick - DIV_W'(1);
            end else if (last) begin
               // word is left unshifted so so keeps the final bit while idle
               state <= IDLE;
            end else begin
               bit_cnt <= bit_cnt + BW'(1);
               tick    <= div_l;
               word    <= word << 1;
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_frame_feeder.sv
// Bench for serial_frame_feeder: per-cycle comparison against a frame-timing model
// plus literal expectations for each directed scenario.
module tb_serial_frame_feeder;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  div;
   logic        msb_first;
   logic        so, so_en, busy, done;
   logic [15:0] frame_cnt;
   logic        in_ready2, so2, so_en2, busy2, done2;
   logic [1:0]  frame_cnt2;

   serial_frame_feeder #(.WIDTH(8), .DIV_W(4), .FCW(16)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .div(div), .msb_first(msb_first), .so(so),
      .so_en(so_en), .busy(busy), .done(done), .frame_cnt(frame_cnt)
   );

   serial_frame_feeder #(.WIDTH(8), .DIV_W(4), .FCW(2)) dut2 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready2), .div(div), .msb_first(msb_first), .so(so2),
      .so_en(so_en2), .busy(busy2), .done(done2), .frame_cnt(frame_cnt2)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model state: a frame is described only by cycles elapsed since its accepting
   // edge, the latched divider and the bits in transmission order.
   bit       m_act;
   int       m_off, m_div, m_cnt;
   bit       m_so;
   bit [7:0] m_bits;
   int       acc_cyc;

   int       n_str, n_done, n_rb, first_str, last_str;
   bit [7:0] rx;

   initial begin : monitor
      bit e_strobe, e_last, e_ready, e_so;
      int k;
      m_act = 0; m_cnt = 0; m_so = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            m_act = 0; m_cnt = 0; m_so = 0;
            chk("rst_so", so, 0);
            chk("rst_so_en", so_en, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_frame_cnt", frame_cnt, 0);
         end else begin
            if (m_act) begin
               k        = m_off / (m_div + 1);
               e_strobe = (m_off % (m_div + 1)) == m_div;
               e_last   = e_strobe && (k == 7);
               e_ready  = e_last;
               e_so     = m_bits[k];
            end else begin
               e_strobe = 0; e_last = 0; e_ready = 1; e_so = m_so;
            end
            chk("so", so, e_so);
            chk("so_en", so_en, e_strobe);
            chk("busy", busy, m_act);
            chk("done", done, e_last);
            chk("in_ready", in_ready, e_ready);
            chk("frame_cnt", frame_cnt, m_cnt);

            if (so_en === 1'b1) begin
               n_str++;
               if (n_str == 1) first_str = cyc;
               last_str = cyc;
               rx = {rx[6:0], so};
            end
            if (done === 1'b1) n_done++;
            if (in_ready === 1'b1 && busy === 1'b1) n_rb++;

            if (e_last) begin
               m_cnt = (m_cnt + 1) % 65536;
               m_so  = e_so;
            end
            if (in_valid && e_ready) begin
               m_act = 1; m_off = 0; m_div = div; acc_cyc = cyc + 1;
               for (int i = 0; i < 8; i++)
                  m_bits[i] = msb_first ? in_data[7-i] : in_data[i];
            end else if (m_act) begin
               if (e_last) m_act = 0;
               else m_off++;
            end
         end
      end
   end

   task automatic clr_mon();
      n_str = 0; n_done = 0; n_rb = 0; rx = '0; first_str = 0; last_str = 0;
   endtask

   task automatic rst_check(input string tag);
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      chk({tag, "_imm_so"}, so, 0);
      chk({tag, "_imm_so_en"}, so_en, 0);
      chk({tag, "_imm_busy"}, busy, 0);
      chk({tag, "_imm_done"}, done, 0);
      chk({tag, "_imm_frame_cnt"}, frame_cnt, 0);
      chk({tag, "_imm_frame_cnt2"}, frame_cnt2, 0);
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk({tag, "_ready_after_release"}, in_ready, 1);
      @(posedge clk); #2;
      clr_mon();
   endtask

   task automatic send(input logic [7:0] d, input int dv, input bit mf);
      in_data = d; div = dv[3:0]; msb_first = mf; in_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (in_ready === 1'b1) begin
            @(posedge clk); #1;
            in_valid = 1'b0; in_data = ~d; div = 4'(dv + 3); msb_first = ~mf;
            return;
         end
      end
      chk("send_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            @(posedge clk); #2;
            return;
         end
      end
      chk("done_timeout", 0, 1);
   endtask

   int exp6[5] = '{1, 2, 3, 0, 1};

   initial begin : stim
      rst = 1'b0; in_valid = 1'b0; in_data = '0; div = '0; msb_first = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;

      // reset during activity
      in_data = 8'hFF; div = 4'd1; msb_first = 1'b1; in_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1 in_valid = 1'b0;
      rst_check("t1");

      // div=0, MSB first
      send(8'b10110010, 0, 1);
      wait_done();
      chk("t2_rx", rx, 8'b10110010);
      chk("t2_strobes", n_str, 8);
      chk("t2_span", last_str - first_str, 7);
      chk("t2_latency", first_str - acc_cyc, 0);
      chk("t2_done_cnt", n_done, 1);
      rst_check("t2");

      // div=2, LSB first, settings disturbed after accept
      send(8'hA5, 2, 0);
      wait_done();
      chk("t3_rx", rx, 8'hA5);
      chk("t3_strobes", n_str, 8);
      chk("t3_latency", first_str - acc_cyc, 2);
      chk("t3_span", last_str - first_str, 21);
      chk("t3_frame_cnt", frame_cnt, 1);
      rst_check("t3");

      // back-to-back with in_valid held
      send(8'h3C, 0, 1);
      send(8'hC3, 0, 1);
      wait_done();
      chk("t4_strobes", n_str, 16);
      chk("t4_span", last_str - first_str, 15);
      chk("t4_ready_in_shift", n_rb, 2);
      chk("t4_rx", rx, 8'hC3);
      chk("t4_frame_cnt", frame_cnt, 2);
      rst_check("t4");

      // ignored mid-frame word, then reset at bit 4
      send(8'h96, 1, 1);
      in_valid = 1'b1; in_data = 8'hFF;
      @(negedge clk);
      chk("t5_ready_mid", in_ready, 0);
      @(posedge clk); #1 in_valid = 1'b0;
      for (int i = 0; i < 100 && n_str < 4; i++) begin
         @(posedge clk); #2;
      end
      chk("t5_reached_bit4", n_str >= 4, 1);
      chk("t5_no_done", n_done, 0);
      rst_check("t5");
      send(8'h96, 0, 0);
      wait_done();
      chk("t5_strobes", n_str, 8);
      chk("t5_rx", rx, 8'h69);
      chk("t5_frame_cnt", frame_cnt, 1);
      rst_check("t5b");

      // 2-bit frame counter wrap
      for (int i = 0; i < 5; i++) begin
         send(8'(8'h11 * (i + 1)), 0, 1);
         wait_done();
         chk("t6_frame_cnt2", frame_cnt2, exp6[i]);
         chk("t6_frame_cnt", frame_cnt, i + 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
